// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: state encoding, halt word
// and big-endian byte-lane placement.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_TERM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam int          LANES     = 4;
  localparam logic [31:0] HALT_WORD = 32'h0;

  // Byte k of a word (k = 0 first on the stream) lands in the most significant lane.
  function automatic int lane_lsb(input logic [1:0] k, input int byte_w);
    return (LANES - 1 - int'(k)) * byte_w;
  endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Packs accepted stream bytes into big-endian words; word_valid_o pulses
// combinationally on the fourth accepted byte.
module byte_packer
  import instr_loader_pkg::*;
#(
  parameter int BYTE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  input  logic                      accept_i,
  input  logic [BYTE_W-1:0]         byte_i,
  output logic                      word_valid_o,
  output logic [LANES*BYTE_W-1:0]   word_o
);

  logic [1:0]              cnt_q, cnt_d;
  logic [LANES*BYTE_W-1:0] buf_q, buf_d;

  always_comb begin
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    word_valid_o = 1'b0;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (accept_i) begin
      buf_d[lane_lsb(cnt_q, BYTE_W) +: BYTE_W] = byte_i;
      cnt_d        = cnt_q + 2'd1;
      word_valid_o = (cnt_q == 2'd3);
    end
    // Completed word includes the byte arriving this cycle.
    word_o = buf_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Streams a length-prefixed program into instruction memory, appends the halt
// word and holds the processor in reset until the load completes.
// Handshake: a byte transfers on a rising edge where s_valid && s_ready; s_ready
// depends on the state register only and s_valid may be withdrawn at any time.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              proc_rst_n,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        dbg_state
);

  localparam logic [31:0]     MAX_N = 32'((1 << ADDR_W) - 1);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

  state_e                  state_q, state_d;
  logic [ADDR_W:0]         n_q, n_d;
  logic [ADDR_W:0]         idx_q, idx_d;
  logic                    pend_q, pend_d;
  logic [31:0]             pend_data_q, pend_data_d;
  logic                    accept;
  logic                    packer_clear;
  logic                    word_valid;
  logic [LANES*BYTE_W-1:0] word;

  assign s_ready      = (state_q == ST_HDR) || (state_q == ST_LOAD);
  assign accept       = s_valid && s_ready;
  assign proc_rst_n   = (state_q == ST_DONE);
  assign load_done    = (state_q == ST_DONE);
  assign load_err     = (state_q == ST_ERR);
  assign words_loaded = idx_q;
  assign dbg_state    = state_q;

  byte_packer #(.BYTE_W(BYTE_W)) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (packer_clear),
    .accept_i     (accept),
    .byte_i       (s_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    pend_data_d  = pend_data_q;
    packer_clear = 1'b0;
    imem_we      = 1'b0;
    imem_addr    = 32'h0;
    imem_wdata   = 32'h0;

    // A word registered in LOAD writes on the following cycle.
    if (pend_q) begin
      imem_we    = 1'b1;
      imem_addr  = 32'(idx_q) << 2;
      imem_wdata = pend_data_q;
      pend_d     = 1'b0;
      idx_d      = idx_q + ONE;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d      = ST_HDR;
          n_d          = '0;
          idx_d        = '0;
          pend_d       = 1'b0;
          packer_clear = 1'b1;
        end
      end
      ST_HDR: begin
        if (word_valid) begin
          if (32'(word) > MAX_N) begin
            state_d = ST_ERR;
          end else begin
            n_d     = word[ADDR_W:0];
            idx_d   = '0;
            state_d = (32'(word) == 32'h0) ? ST_TERM : ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (word_valid) begin
          pend_d      = 1'b1;
          pend_data_d = 32'(word);
          if ((idx_q + ONE) == n_q) state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        // The halt word waits until the last program word has drained.
        if (!pend_q) begin
          imem_we    = 1'b1;
          imem_addr  = 32'(n_q) << 2;
          imem_wdata = HALT_WORD;
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed sequences, a table of load scenarios with
// random payloads, and a write scoreboard fed by a program-level model.
module tb_instr_loader;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_wdata;
  logic              proc_rst_n;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;
  logic [2:0]        dbg_state;

  instr_loader #(.ADDR_W(ADDR_W), .BYTE_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .proc_rst_n   (proc_rst_n),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  stream_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_write: got addr %h data %h want no write", imem_addr, imem_wdata);
      end else begin
        check("write_addr", imem_addr, exp_addr_q.pop_front());
        check("write_data", imem_wdata, exp_data_q.pop_front());
      end
    end
  end

  // Program-level model: header N, then N random words, then the halt word at N*4.
  task automatic build(input logic [31:0] hdr);
    logic [31:0] w;
    stream_q.delete();
    for (int b = 3; b >= 0; b--) stream_q.push_back(hdr[b*8 +: 8]);
    if (hdr <= 32'd255) begin
      for (int i = 0; i < int'(hdr); i++) begin
        w = $urandom;
        for (int b = 3; b >= 0; b--) stream_q.push_back(w[b*8 +: 8]);
        exp_addr_q.push_back(32'(i * 4));
        exp_data_q.push_back(w);
      end
      exp_addr_q.push_back(hdr * 4);
      exp_data_q.push_back(32'h0);
    end
  endtask

  // ---------------- driver tasks (entered/left at posedge + 1) ----------------
  task automatic pulse_start(input bit with_byte);
    start = 1'b1;
    if (with_byte) begin
      s_valid = 1'b1;
      s_data  = 8'hAA;
    end
    @(posedge clk); #1;
    start   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("start_state", 32'(dbg_state), 32'd1);
    check("start_ready", 32'(s_ready), 32'd1);
    check("start_done", 32'(load_done), 32'd0);
    check("start_prst", 32'(proc_rst_n), 32'd0);
    check("start_err", 32'(load_err), 32'd0);
    check("start_words", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_stream(input bit stall, input int count);
    int   guard;
    logic rdy;
    for (int k = 0; k < count; k++) begin
      if (stall && (k % 4 == 2)) begin
        s_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_ready", 32'(s_ready), 32'd1);
          @(posedge clk); #1;
        end
      end
      s_valid = 1'b1;
      s_data  = stream_q[k];
      guard   = 0;
      do begin
        @(negedge clk);
        rdy = s_ready;
        @(posedge clk); #1;
        guard++;
      end while (!rdy && guard < 20);
      if (!rdy) begin
        check("byte_accept_timeout", 32'(rdy), 32'd1);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_end(input logic exp_done, input logic exp_err, input logic [ADDR_W:0] exp_words);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(load_done || load_err) && g < 40);
    check("end_done", 32'(load_done), 32'(exp_done));
    check("end_err", 32'(load_err), 32'(exp_err));
    check("end_prst", 32'(proc_rst_n), 32'(exp_done));
    check("end_words", 32'(words_loaded), 32'(exp_words));
    check("end_ready", 32'(s_ready), 32'd0);
    check("end_state", 32'(dbg_state), exp_done ? 32'd4 : 32'd5);
    repeat (3) @(negedge clk);
    check("writes_outstanding", 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0]     hdr;
    bit              stall;
    logic            exp_done;
    logic            exp_err;
    logic [ADDR_W:0] exp_words;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] t1[12];
    logic [31:0] rn;
    t1 = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
           8'h01, 8'h09, 8'h50, 8'h20};
    rn = 32'($urandom_range(4, 12));

    vecs[0]  = '{32'd2,         1'b0, 1'b1, 1'b0, 9'd2};
    vecs[1]  = '{32'd0,         1'b0, 1'b1, 1'b0, 9'd0};
    vecs[2]  = '{32'd256,       1'b0, 1'b0, 1'b1, 9'd0};
    vecs[3]  = '{32'd1,         1'b0, 1'b1, 1'b0, 9'd1};
    vecs[4]  = '{32'd3,         1'b1, 1'b1, 1'b0, 9'd3};
    vecs[5]  = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 9'd0};
    vecs[6]  = '{32'd0,         1'b1, 1'b1, 1'b0, 9'd0};
    vecs[7]  = '{32'd255,       1'b0, 1'b1, 1'b0, 9'd255};
    vecs[8]  = '{32'h0001_0000, 1'b0, 1'b0, 1'b1, 9'd0};
    vecs[9]  = '{rn,            1'b1, 1'b1, 1'b0, rn[ADDR_W:0]};
    vecs[10] = '{32'd1,         1'b1, 1'b1, 1'b0, 9'd1};

    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    rst_n   = 1'b0;
    #23;
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_prst", 32'(proc_rst_n), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed two-word program, back-to-back then with mid-word stalls.
    for (int pass = 0; pass < 2; pass++) begin
      stream_q.delete();
      for (int k = 0; k < 12; k++) stream_q.push_back(t1[k]);
      exp_addr_q.push_back(32'd0); exp_data_q.push_back(32'h2008_0005);
      exp_addr_q.push_back(32'd4); exp_data_q.push_back(32'h0109_5020);
      exp_addr_q.push_back(32'd8); exp_data_q.push_back(32'h0000_0000);
      pulse_start(1'b0);
      send_stream(pass == 1, stream_q.size());
      wait_end(1'b1, 1'b0, 9'd2);
    end

    // Table of scenarios, each restarting from the previous DONE/ERR state.
    for (int v = 0; v < 11; v++) begin
      build(vecs[v].hdr);
      pulse_start(1'b0);
      send_stream(vecs[v].stall, stream_q.size());
      wait_end(vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_words);
    end

    // Asynchronous reset after 5 bytes of a 2-word program.
    stream_q.delete();
    build(32'd2);
    exp_addr_q.delete();
    exp_data_q.delete();
    pulse_start(1'b0);
    send_stream(1'b0, 5);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(dbg_state), 32'd0);
    check("arst_ready", 32'(s_ready), 32'd0);
    check("arst_we", 32'(imem_we), 32'd0);
    check("arst_prst", 32'(proc_rst_n), 32'd0);
    check("arst_words", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_ready", 32'(s_ready), 32'd0);
      check("idle_state", 32'(dbg_state), 32'd0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;

    // A byte offered alongside start must not be consumed.
    build(32'd1);
    pulse_start(1'b1);
    send_stream(1'b0, stream_q.size());
    wait_end(1'b1, 1'b0, 9'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
